// File: rtl/touch_scan_sequencer.sv
// ---------------------------------------------------------------------------
// touch_scan_sequencer
//
// Periodic scan scheduler for the resistive touchpad. After an idle interval
// it asks the serial conversion engine for a pressure (Z) reading. If that
// reading shows pen contact, it then requests X and then Y. Every
// 2^AVG_LOG2 accepted scans it publishes the averaged X/Y, the Z of the last
// scan, and a pen-down flag. A low-pressure scan discards the partial set.
//
// Parameters
//   SAMPLE_PERIOD  idle cycles between the end of one scan and the next (>= 2)
//   AVG_LOG2       log2 of the number of scans averaged per output (0..4)
//   Z_THRESH       minimum 9-bit Z reading counted as pen contact
//
// Ports
//   cclk          system clock, rising edge
//   rstb          asynchronous active-low reset
//   enable        scanning permitted (a scan already started always completes)
//   conv_req      conversion request to the serial engine
//   conv_chan     channel select: 00 = X, 01 = Y, 10 = Z
//   conv_ack      one-cycle pulse: conversion done, conv_data valid
//   conv_data     conversion result
//   touch_x/y     averaged coordinates
//   touch_z       Z of the last scan in the averaged set
//   pen_down      pen contact status
//   sample_valid  one-cycle pulse when touch_x/y/z update
//   busy          high whenever a scan is in progress
// ---------------------------------------------------------------------------
module touch_scan_sequencer #(
   parameter int SAMPLE_PERIOD = 50000,
   parameter int AVG_LOG2      = 2,
   parameter int Z_THRESH      = 20
) (
   input  logic       cclk,
   input  logic       rstb,
   input  logic       enable,
   output logic       conv_req,
   output logic [1:0] conv_chan,
   input  logic       conv_ack,
   input  logic [8:0] conv_data,
   output logic [8:0] touch_x,
   output logic [8:0] touch_y,
   output logic [8:0] touch_z,
   output logic       pen_down,
   output logic       sample_valid,
   output logic       busy
);

   localparam int TW = $clog2(SAMPLE_PERIOD);
   localparam int SW = 9 + AVG_LOG2;      // sum of 2^AVG_LOG2 nine-bit samples never overflows
   localparam int CW = AVG_LOG2 + 1;      // must hold the value 2^AVG_LOG2 itself

   localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
   localparam logic [CW-1:0] SCANS      = CW'(1 << AVG_LOG2);
   localparam logic [8:0]    Z_MIN      = 9'(Z_THRESH);

   localparam logic [1:0] CHAN_X = 2'b00;
   localparam logic [1:0] CHAN_Y = 2'b01;
   localparam logic [1:0] CHAN_Z = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      REQ_Z,
      WAIT_Z,
      REQ_X,
      WAIT_X,
      REQ_Y,
      WAIT_Y
   } state_t;

   state_t          state, state_d;
   logic [TW-1:0]   timer, timer_d;
   logic [CW-1:0]   scan_cnt, scan_cnt_d, scan_cnt_inc;
   logic [SW-1:0]   sum_x, sum_x_d, sum_x_new;
   logic [SW-1:0]   sum_y, sum_y_d, sum_y_new;
   logic [8:0]      z_lat, z_lat_d;
   logic            conv_req_d;
   logic [1:0]      conv_chan_d;
   logic [8:0]      touch_x_d, touch_y_d, touch_z_d;
   logic            pen_down_d, sample_valid_d;
   logic            ack_ok;

   // An ack only counts while a request is actually outstanding.
   assign ack_ok       = conv_ack & conv_req;
   assign sum_x_new    = sum_x + SW'(conv_data);
   assign sum_y_new    = sum_y + SW'(conv_data);
   assign scan_cnt_inc = scan_cnt + 1'b1;
   assign busy         = (state != IDLE);

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d        = state;
      timer_d        = timer;
      scan_cnt_d     = scan_cnt;
      sum_x_d        = sum_x;
      sum_y_d        = sum_y;
      z_lat_d        = z_lat;
      conv_req_d     = conv_req;
      conv_chan_d    = conv_chan;
      touch_x_d      = touch_x;
      touch_y_d      = touch_y;
      touch_z_d      = touch_z;
      pen_down_d     = pen_down;
      sample_valid_d = 1'b0;

      unique case (state)
         IDLE: begin
            if (!enable) begin
               timer_d = '0;
            end else if (timer == TIMER_LAST) begin
               timer_d = '0;
               state_d = REQ_Z;
            end else begin
               timer_d = timer + 1'b1;
            end
         end

         REQ_Z: begin
            conv_req_d  = 1'b1;
            conv_chan_d = CHAN_Z;
            state_d     = WAIT_Z;
         end

         WAIT_Z: begin
            if (ack_ok) begin
               conv_req_d = 1'b0;
               if (conv_data < Z_MIN) begin
                  // Pen lifted: the partial averaging set is worthless.
                  pen_down_d = 1'b0;
                  scan_cnt_d = '0;
                  sum_x_d    = '0;
                  sum_y_d    = '0;
                  state_d    = IDLE;
               end else begin
                  z_lat_d = conv_data;
                  state_d = REQ_X;
               end
            end
         end

         REQ_X: begin
            conv_req_d  = 1'b1;
            conv_chan_d = CHAN_X;
            state_d     = WAIT_X;
         end

         WAIT_X: begin
            if (ack_ok) begin
               conv_req_d = 1'b0;
               sum_x_d    = sum_x_new;
               state_d    = REQ_Y;
            end
         end

         REQ_Y: begin
            conv_req_d  = 1'b1;
            conv_chan_d = CHAN_Y;
            state_d     = WAIT_Y;
         end

         WAIT_Y: begin
            if (ack_ok) begin
               conv_req_d = 1'b0;
               state_d    = IDLE;
               if (scan_cnt_inc == SCANS) begin
                  // X already holds this scan's sample; Y is folded in here.
                  touch_x_d      = 9'(sum_x >> AVG_LOG2);
                  touch_y_d      = 9'(sum_y_new >> AVG_LOG2);
                  touch_z_d      = z_lat;
                  pen_down_d     = 1'b1;
                  sample_valid_d = 1'b1;
                  scan_cnt_d     = '0;
                  sum_x_d        = '0;
                  sum_y_d        = '0;
               end else begin
                  sum_y_d    = sum_y_new;
                  scan_cnt_d = scan_cnt_inc;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge cclk or negedge rstb) begin
      if (!rstb) begin
         state        <= IDLE;
         timer        <= '0;
         scan_cnt     <= '0;
         sum_x        <= '0;
         sum_y        <= '0;
         z_lat        <= '0;
         conv_req     <= 1'b0;
         conv_chan    <= 2'b00;
         touch_x      <= '0;
         touch_y      <= '0;
         touch_z      <= '0;
         pen_down     <= 1'b0;
         sample_valid <= 1'b0;
      end else begin
         state        <= state_d;
         timer        <= timer_d;
         scan_cnt     <= scan_cnt_d;
         sum_x        <= sum_x_d;
         sum_y        <= sum_y_d;
         z_lat        <= z_lat_d;
         conv_req     <= conv_req_d;
         conv_chan    <= conv_chan_d;
         touch_x      <= touch_x_d;
         touch_y      <= touch_y_d;
         touch_z      <= touch_z_d;
         pen_down     <= pen_down_d;
         sample_valid <= sample_valid_d;
      end
   end

endmodule

// File: tb/tb_touch_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_touch_scan_sequencer
//
// Two sequencers share one stimulus stream: u_dut_a averages four scans,
// u_dut_b (AVG_LOG2 = 0) publishes every good scan. The bench plays the
// serial engine, answering each request with data from a scan description,
// and a reference model predicts the published coordinates from plain
// running sums and counts.
// ---------------------------------------------------------------------------
module tb_touch_scan_sequencer;

   localparam int SP = 8;
   localparam int AL = 2;
   localparam int ZT = 20;
   localparam int N  = 1 << AL;

   localparam logic [1:0] CH_X = 2'b00;
   localparam logic [1:0] CH_Y = 2'b01;
   localparam logic [1:0] CH_Z = 2'b10;

   logic       cclk = 1'b0;
   logic       rstb;
   logic       enable;
   logic       conv_ack;
   logic [8:0] conv_data;

   logic       req_a, req_b, pen_a, pen_b, sv_a, sv_b, busy_a, busy_b;
   logic [1:0] chan_a, chan_b;
   logic [8:0] tx_a, ty_a, tz_a, tx_b, ty_b, tz_b;

   int n_vec = 0;
   int n_err = 0;

   always #5 cclk = ~cclk;

   touch_scan_sequencer #(.SAMPLE_PERIOD(SP), .AVG_LOG2(AL), .Z_THRESH(ZT)) u_dut_a (
      .cclk(cclk), .rstb(rstb), .enable(enable),
      .conv_req(req_a), .conv_chan(chan_a), .conv_ack(conv_ack), .conv_data(conv_data),
      .touch_x(tx_a), .touch_y(ty_a), .touch_z(tz_a),
      .pen_down(pen_a), .sample_valid(sv_a), .busy(busy_a)
   );

   touch_scan_sequencer #(.SAMPLE_PERIOD(SP), .AVG_LOG2(0), .Z_THRESH(ZT)) u_dut_b (
      .cclk(cclk), .rstb(rstb), .enable(enable),
      .conv_req(req_b), .conv_chan(chan_b), .conv_ack(conv_ack), .conv_data(conv_data),
      .touch_x(tx_b), .touch_y(ty_b), .touch_z(tz_b),
      .pen_down(pen_b), .sample_valid(sv_b), .busy(busy_b)
   );

   // Count cycles with sample_valid high (sampled mid-cycle).
   int nv_a = 0;
   int nv_b = 0;
   always @(negedge cclk) begin
      if (sv_a === 1'b1) nv_a++;
      if (sv_b === 1'b1) nv_b++;
   end

   // Reference model state.
   int         m_cnt, m_sx, m_sy;
   logic [8:0] ea_x, ea_y, ea_z, eb_x, eb_y, eb_z;
   logic       ea_pen, eb_pen;
   int         ea_nv, eb_nv;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_sx = 0; m_sy = 0;
      ea_x = '0; ea_y = '0; ea_z = '0; ea_pen = 1'b0;
      eb_x = '0; eb_y = '0; eb_z = '0; eb_pen = 1'b0;
   endtask

   task automatic model_scan(input int z, input int x, input int y);
      if (z < ZT) begin
         m_cnt = 0; m_sx = 0; m_sy = 0;
         ea_pen = 1'b0;
         eb_pen = 1'b0;
      end else begin
         m_sx += x; m_sy += y; m_cnt++;
         if (m_cnt == N) begin
            ea_x = 9'(m_sx / N); ea_y = 9'(m_sy / N); ea_z = 9'(z);
            ea_pen = 1'b1; ea_nv++;
            m_cnt = 0; m_sx = 0; m_sy = 0;
         end
         eb_x = 9'(x); eb_y = 9'(y); eb_z = 9'(z); eb_pen = 1'b1; eb_nv++;
      end
   endtask

   task automatic check_outputs(input string tag);
      #1;
      check({tag, ".x_a"},   tx_a,  ea_x);
      check({tag, ".y_a"},   ty_a,  ea_y);
      check({tag, ".z_a"},   tz_a,  ea_z);
      check({tag, ".pen_a"}, pen_a, ea_pen);
      check({tag, ".nv_a"},  nv_a,  ea_nv);
      check({tag, ".x_b"},   tx_b,  eb_x);
      check({tag, ".y_b"},   ty_b,  eb_y);
      check({tag, ".z_b"},   tz_b,  eb_z);
      check({tag, ".pen_b"}, pen_b, eb_pen);
      check({tag, ".nv_b"},  nv_b,  eb_nv);
   endtask

   // Serve one conversion: wait for the request, check the channel and its
   // stability, then ack after dly cycles. Called and returns on a negedge.
   task automatic serve(input logic [1:0] ch, input logic [8:0] d, input int dly,
                        input int exp_wait, input bit inject, input bit drop_en,
                        output bit ok);
      int t;
      t  = 0;
      ok = 1'b1;
      while (req_a !== 1'b1 && t < 4 * SP + 100) begin
         @(negedge cclk);
         t++;
         if (inject) conv_ack = (t == 2);
      end
      conv_ack = 1'b0;
      if (req_a !== 1'b1) begin
         check("req_timeout", 32'(req_a), 1);
         ok = 1'b0;
         return;
      end
      if (exp_wait >= 0) check("req_gap", t, exp_wait);
      check("chan_a", chan_a, ch);
      check("chan_b", chan_b, ch);
      check("req_b", req_b, 1);
      check("busy", busy_a, 1);
      for (int i = 1; i < dly; i++) begin
         @(negedge cclk);
         if (drop_en && i == 1) enable = 1'b0;
         check("req_hold", req_a, 1);
         check("chan_hold", chan_a, ch);
      end
      conv_ack  = 1'b1;
      conv_data = d;
      @(negedge cclk);
      conv_ack  = 1'b0;
      conv_data = 9'($urandom);
      check("req_drop_a", req_a, 0);
      check("req_drop_b", req_b, 0);
   endtask

   task automatic scan(input int z, input int x, input int y, input int dly,
                       input int zwait, input bit inject, input bit drop_en);
      bit ok;
      serve(CH_Z, 9'(z), dly, zwait, inject, 1'b0, ok);
      if (!ok) return;
      if (z < ZT) begin
         model_scan(z, x, y);
         check_outputs("penup");
         check("penup_busy", busy_a, 0);
         return;
      end
      serve(CH_X, 9'(x), dly, 1, 1'b0, 1'b0, ok);
      if (!ok) return;
      serve(CH_Y, 9'(y), dly, 1, 1'b0, drop_en, ok);
      if (!ok) return;
      model_scan(z, x, y);
      check_outputs("scan");
      check("scan_busy", busy_a, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      ea_nv = 0; eb_nv = 0;
      model_reset();
      rstb = 1'b0; enable = 1'b1; conv_ack = 1'b0; conv_data = '0;

      // Reset state.
      repeat (3) @(negedge cclk);
      check_outputs("reset");
      check("reset_req", req_a, 0);
      check("reset_chan", chan_a, 0);
      check("reset_busy", busy_a, 0);
      check("reset_sv", sv_a, 0);
      rstb = 1'b1;

      // Averaging: Z=50, X=100..112, Y=200.
      for (int i = 0; i < 4; i++) scan(50, 100 + 4 * i, 200, 5, SP + 1, 1'b0, 1'b0);
      check("avg_x", tx_a, 106);
      check("avg_y", ty_a, 200);
      check("avg_z", tz_a, 50);
      check("avg_pen", pen_a, 1);

      // Pen-up gating.
      scan(10, 0, 0, 5, SP + 1, 1'b0, 1'b0);
      check("penup_pen", pen_a, 0);

      // Mid-set discard.
      for (int i = 0; i < 2; i++) scan(40, 400, 300, 3, SP + 1, 1'b0, 1'b0);
      scan(5, 0, 0, 3, SP + 1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) scan(30, 40, 60, 3, SP + 1, 1'b0, 1'b0);
      check("discard_x", tx_a, 40);

      // Handshake robustness: long ack delay, stray ack in IDLE, enable drop.
      scan(90, 10, 20, 37, SP + 1, 1'b0, 1'b0);
      scan(90, 12, 22, 4, SP + 1, 1'b1, 1'b0);
      scan(90, 14, 24, 4, SP + 1, 1'b0, 1'b1);
      for (int i = 0; i < 3 * SP; i++) begin
         @(negedge cclk);
         check("disabled_req", req_a, 0);
         check("disabled_busy", busy_a, 0);
      end
      enable = 1'b1;
      scan(90, 16, 26, 4, SP + 1, 1'b0, 1'b0);
      check("robust_x", tx_a, 13);

      // Boundary: full-scale X, zero Y.
      for (int i = 0; i < 4; i++) scan(511, 511, 0, 2, SP + 1, 1'b0, 1'b0);
      check("bound_x", tx_a, 511);
      check("bound_y", ty_a, 0);

      // Reset mid-WAIT_X.
      serve(CH_Z, 9'd100, 2, SP + 1, 1'b0, 1'b0, ok);
      repeat (3) @(negedge cclk);
      check("pre_rst_req", req_a, 1);
      rstb = 1'b0;
      model_reset();
      check_outputs("mid_rst");
      check("mid_rst_req", req_a, 0);
      check("mid_rst_busy", busy_a, 0);
      repeat (2) @(negedge cclk);
      rstb = 1'b1;
      scan(60, 200, 100, 3, SP + 1, 1'b0, 1'b0);

      // Randomized scans.
      for (int i = 0; i < 40; i++) begin
         scan(int'($urandom_range(0, 60)), int'($urandom_range(0, 511)),
              int'($urandom_range(0, 511)), int'($urandom_range(1, 8)),
              SP + 1, 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/touch_scan_sequencer.md
# touch_scan_sequencer

Periodic scan scheduler for the resistive touchpad. It sequences the serial conversion engine through pressure (Z), X and Y conversions on a fixed interval and gates X/Y on a pressure threshold. It averages 2^AVG_LOG2 accepted scans and publishes one filtered coordinate with a pen-down flag. It sits between the serial touchpad engine (below) and display/game logic (above) in the cclk domain.

## Interface
Parameters:
- SAMPLE_PERIOD, 50000: idle cycles between the end of one scan and the start of the next (≥ 2)
- AVG_LOG2, 2: log2 of the number of scans averaged per output (0..4)
- Z_THRESH, 20: minimum 9-bit Z reading counted as pen contact

Ports:
- cclk  in  1  system clock; all logic on the rising edge
- rstb  in  1  asynchronous, active-low reset
- enable  in  1  scanning permitted
- conv_req  out  1  conversion request to the serial engine
- conv_chan  out  2  channel select: 00 = X, 01 = Y, 10 = Z (11 never driven)
- conv_ack  in  1  one-cycle pulse: conversion done, conv_data valid
- conv_data  in  9  conversion result, sampled only on conv_ack
- touch_x  out  9  averaged X
- touch_y  out  9  averaged Y
- touch_z  out  9  Z of the last scan in the set
- pen_down  out  1  pen contact status
- sample_valid  out  1  one-cycle pulse when touch_x/y/z update
- busy  out  1  high whenever state ≠ IDLE

## Operation
- Reset values (asynchronous): all outputs 0, state IDLE, timer 0, scan count 0, X and Y sums 0.
- States: IDLE, REQ_Z, WAIT_Z, REQ_X, WAIT_X, REQ_Y, WAIT_Y.
- IDLE:
  - timer increments while enable = 1 and is held at 0 while enable = 0.
  - At timer = SAMPLE_PERIOD−1, clear the timer and go to REQ_Z.
- REQ_*:
  - Drive conv_req = 1 with conv_chan set for that channel, then go to WAIT_*.
  - conv_req and conv_chan hold stable until the ack edge.
- WAIT_*:
  - On conv_ack = 1, drop conv_req on that edge and latch conv_data.
  - conv_ack while conv_req = 0 is ignored.
- Z result < Z_THRESH (pen-up):
  - pen_down ← 0; clear scan count and sums; return to IDLE.
  - X and Y are not requested; sample_valid stays 0.
- Z ≥ Z_THRESH: latch Z, then go to REQ_X.
- X ack: sum_x += conv_data; go to REQ_Y.
- Y ack: sum_y += conv_data and increment the scan count. If the count reaches 2^AVG_LOG2, on the same edge:
  - touch_x ← (sum_x incl. this sample) >> AVG_LOG2; touch_y likewise.
  - touch_z ← latched Z; pen_down ← 1; sample_valid ← 1.
  - Clear count and sums.
- After the Y ack, always return to IDLE.
- Sums are 9+AVG_LOG2 bits wide, so no overflow; the shift truncates (floor).
- enable low mid-scan: the current sequence completes normally. A pending handshake is never abandoned.
- Outputs hold between updates.

## Timing
- Scan start: conv_req rises on the edge after the timer reaches terminal count. The interval from return-to-IDLE to the next conv_req rise is SAMPLE_PERIOD+1 cycles.
- Between requests, conv_req is low for exactly one cycle (ack edge → REQ edge → high).
- Output latency: touch_* and sample_valid update on the edge that samples the final Y ack. sample_valid is high for exactly one cycle.
- Pen-up: pen_down falls on the edge that samples the low-Z ack.
- rstb low at any time, including mid-handshake: conv_req is 0 immediately and all state is cleared.

## Test plan
- Reset: hold rstb low 3 cycles → all outputs 0. Assert rstb mid-WAIT_X → conv_req goes 0 asynchronously; after release, the first conv_req rises only after SAMPLE_PERIOD cycles.
- Averaging (SAMPLE_PERIOD=8, AVG_LOG2=2, Z_THRESH=20; model acks after 5 cycles):
  - Stimulus: Z=50; X = 100, 104, 108, 112; Y = 200 ×4.
  - Expect: channel order Z, X, Y each scan; exactly one sample_valid, after the 4th Y ack; touch_x=106, touch_y=200, touch_z=50, pen_down=1.
- Pen-up gating: after the above, return Z=10 → no X/Y request; pen_down falls on that ack edge; no sample_valid.
- Mid-set discard: 2 good scans (X=400), 1 pen-up scan, then 4 good scans (X=40) → the single sample_valid reports touch_x=40.
- Handshake robustness:
  - Delay ack 37 cycles → conv_req and conv_chan stable throughout.
  - Inject conv_ack while conv_req=0 → no state change.
  - Drop enable during WAIT_Y → scan completes, then no further conv_req until enable returns.
- Boundary: X=511, Y=0 on all 4 scans → touch_x=511, touch_y=0 (no overflow). AVG_LOG2=0 → sample_valid after every good scan.
